// File: rtl/alu_exec_unit_pkg.sv
// Shared types for the ALU execute-stage controller: opcode and FSM encodings.
package alu_exec_unit_pkg;

  localparam int unsigned DataW = 8;

  typedef enum logic [1:0] {
    OpAnd  = 2'b00,
    OpOr   = 2'b01,
    OpAdd  = 2'b10,
    OpSubn = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StWb   = 2'b10
  } exec_state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Command, ALU-side, result and debug signals of the execute-stage controller.
// master: the parent (command source and host of bit_8_ALU); slave: alu_exec_unit.
interface alu_exec_unit_if #(
  parameter int unsigned REG_AW = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [REG_AW-1:0] cmd_rd;
  logic [REG_AW-1:0] cmd_rs1;
  logic [REG_AW-1:0] cmd_rs2;
  logic              cmd_imm_en;
  logic [7:0]        cmd_imm;
  logic [7:0]        alu_a;
  logic [7:0]        alu_b;
  logic [1:0]        alu_op;
  logic [7:0]        alu_result;
  logic              res_valid;
  logic [7:0]        res_data;
  logic              zero_flag;
  logic [REG_AW-1:0] dbg_addr;
  logic [7:0]        dbg_data;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm, alu_result, dbg_addr,
    input  cmd_ready, alu_a, alu_b, alu_op, res_valid, res_data, zero_flag, dbg_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm, alu_result, dbg_addr,
    output cmd_ready, alu_a, alu_b, alu_op, res_valid, res_data, zero_flag, dbg_data
  );

endinterface

// File: rtl/alu_exec_unit_regfile.sv
// NREG x 8 register file: two combinational operand reads, one debug read,
// one synchronous write, asynchronous clear.
module alu_exec_unit_regfile #(
  parameter int unsigned REG_AW = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [REG_AW-1:0] raddr_a_i,
  output logic [7:0]        rdata_a_o,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [7:0]        rdata_b_o,
  input  logic [REG_AW-1:0] dbg_addr_i,
  output logic [7:0]        dbg_data_o
);

  localparam int unsigned NReg = 2 ** REG_AW;

  logic [7:0] regs_q [NReg];

  // Register storage: cleared on reset, written at the writeback edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NReg; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = regs_q[raddr_a_i];
  assign rdata_b_o  = regs_q[raddr_b_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage controller around an external bit_8_ALU. One command in flight:
// IDLE (accept, latch operands) -> EXEC (capture ALU result) -> WB (write back).
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned REG_AW = 2
) (
  input logic            clk,
  input logic            reset,
  alu_exec_unit_if.slave bus
);

  exec_state_e       state_q, state_d;
  logic [7:0]        alu_a_q, alu_b_q, res_data_q;
  alu_op_e           alu_op_q;
  logic [REG_AW-1:0] rd_q;
  logic              zero_flag_q;
  logic [7:0]        rs1_data, rs2_data;
  logic              accept;
  logic              wb_en;

  alu_exec_unit_regfile #(
    .REG_AW(REG_AW)
  ) u_regfile (
    .clk_i      (clk),
    .rst_i      (reset),
    .we_i       (wb_en),
    .waddr_i    (rd_q),
    .wdata_i    (res_data_q),
    .raddr_a_i  (bus.cmd_rs1),
    .rdata_a_o  (rs1_data),
    .raddr_b_i  (bus.cmd_rs2),
    .rdata_b_o  (rs2_data),
    .dbg_addr_i (bus.dbg_addr),
    .dbg_data_o (bus.dbg_data)
  );

  // Next-state and handshake decode; commands are only seen in IDLE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    wb_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        accept = bus.cmd_valid;
        if (bus.cmd_valid) state_d = StExec;
      end
      StExec:  state_d = StWb;
      StWb: begin
        wb_en   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand latch at acceptance, result capture in EXEC, flag update in WB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= OpAnd;
      rd_q        <= '0;
      res_data_q  <= '0;
      zero_flag_q <= 1'b0;
    end else begin
      if (accept) begin
        alu_a_q  <= rs1_data;
        alu_b_q  <= bus.cmd_imm_en ? bus.cmd_imm : rs2_data;
        alu_op_q <= alu_op_e'(bus.cmd_op);
        rd_q     <= bus.cmd_rd;
      end
      if (state_q == StExec) begin
        res_data_q <= bus.alu_result;
      end
      if (wb_en) begin
        zero_flag_q <= (res_data_q == 8'h00);
      end
    end
  end

  // Ready is withheld while reset is asserted so nothing is offered mid-clear.
  assign bus.cmd_ready = (state_q == StIdle) && !reset;
  assign bus.res_valid = (state_q == StWb);
  assign bus.res_data  = res_data_q;
  assign bus.zero_flag = zero_flag_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized
// commands checked against a register-file-level reference model.
module tb_alu_exec_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.REG_AW(2)) bus ();

  alu_exec_unit #(
    .REG_AW(2)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] ref_regs [4];
  logic       ref_zero;

  // Arithmetic of the ALU as stated: modulo 256, no carry kept.
  function automatic logic [7:0] ref_alu(input logic [1:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    int s;
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   begin s = int'(a) + int'(b);         return s[7:0]; end
      default: begin s = int'(a) + 255 - int'(b);   return s[7:0]; end
    endcase
  endfunction

  // Stand-in for bit_8_ALU hosted by the parent.
  always_comb bus.alu_result = ref_alu(bus.alu_op, bus.alu_a, bus.alu_b);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;
    ref_zero = 1'b0;
  endtask

  // Call at a negedge; finishes 4ns later.
  task automatic check_reset_state();
    for (int i = 0; i < 4; i++) begin
      bus.dbg_addr = 2'(i);
      #1;
      check_eq("rst_dbg", bus.dbg_data, 8'h00);
    end
    check_eq("rst_ready", bus.cmd_ready, 1);
    check_eq("rst_res_valid", bus.res_valid, 0);
    check_eq("rst_zero", bus.zero_flag, 0);
    check_eq("rst_alu_a", bus.alu_a, 0);
    check_eq("rst_alu_b", bus.alu_b, 0);
    check_eq("rst_alu_op", bus.alu_op, 0);
  endtask

  // Call shortly after a negedge with the unit idle; returns just after the
  // negedge following writeback, ready for a back-to-back command.
  task automatic run_cmd(input logic [1:0] op, input int rd, input int rs1, input int rs2,
                         input logic imm_en, input logic [7:0] imm, input logic scramble);
    logic [7:0] a, b, r;
    a = ref_regs[rs1];
    b = imm_en ? imm : ref_regs[rs2];
    r = ref_alu(op, a, b);
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_rd     = 2'(rd);
    bus.cmd_rs1    = 2'(rs1);
    bus.cmd_rs2    = 2'(rs2);
    bus.cmd_imm_en = imm_en;
    bus.cmd_imm    = imm;
    check_eq("idle_ready", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check_eq("exec_ready", bus.cmd_ready, 0);
    check_eq("exec_res_valid", bus.res_valid, 0);
    check_eq("exec_alu_a", bus.alu_a, a);
    check_eq("exec_alu_b", bus.alu_b, b);
    check_eq("exec_alu_op", bus.alu_op, op);
    if (scramble) begin
      bus.cmd_valid  = 1'($urandom_range(0, 1));
      bus.cmd_op     = 2'($urandom);
      bus.cmd_rd     = 2'($urandom);
      bus.cmd_rs1    = 2'($urandom);
      bus.cmd_rs2    = 2'($urandom);
      bus.cmd_imm_en = 1'($urandom);
      bus.cmd_imm    = 8'($urandom);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check_eq("wb_ready", bus.cmd_ready, 0);
    check_eq("wb_res_valid", bus.res_valid, 1);
    check_eq("wb_res_data", bus.res_data, r);
    ref_regs[rd] = r;
    ref_zero     = (r == 8'h00);
    @(negedge clk);
    bus.dbg_addr = 2'(rd);
    #1;
    check_eq("done_dbg", bus.dbg_data, r);
    check_eq("done_res_valid", bus.res_valid, 0);
    check_eq("done_ready", bus.cmd_ready, 1);
    check_eq("done_zero", bus.zero_flag, ref_zero);
    check_eq("hold_alu_a", bus.alu_a, a);
    check_eq("hold_alu_b", bus.alu_b, b);
  endtask

  initial begin
    int acc, pulses;
    logic [7:0] r5;
    logic ie;

    reset          = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'b00;
    bus.cmd_rd     = '0;
    bus.cmd_rs1    = '0;
    bus.cmd_rs2    = '0;
    bus.cmd_imm_en = 1'b0;
    bus.cmd_imm    = 8'h00;
    bus.dbg_addr   = '0;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_state();
    @(negedge clk);

    // OR R1 = R0 | 0x3C, then ADD chain with wrap, then A+~B and a zero result.
    run_cmd(2'b01, 1, 0, 3, 1'b1, 8'h3C, 1'b0);
    run_cmd(2'b10, 2, 1, 1, 1'b0, 8'h00, 1'b0);
    check_eq("add_r1_r1", bus.dbg_data, 8'h78);
    run_cmd(2'b10, 2, 2, 0, 1'b1, 8'hF0, 1'b0);
    check_eq("add_wrap", bus.dbg_data, 8'h68);
    run_cmd(2'b11, 3, 1, 1, 1'b0, 8'h00, 1'b0);
    check_eq("subn_ff", bus.dbg_data, 8'hFF);
    run_cmd(2'b00, 0, 1, 2, 1'b1, 8'h00, 1'b0);
    check_eq("and_zero_flag", bus.zero_flag, 1);

    // cmd_valid held for 9 cycles: ADD R1 = R1 + 1 repeatedly.
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = 2'b10;
    bus.cmd_rd     = 2'd1;
    bus.cmd_rs1    = 2'd1;
    bus.cmd_imm_en = 1'b1;
    bus.cmd_imm    = 8'h01;
    acc    = 0;
    pulses = 0;
    r5     = 8'h00;
    for (int k = 0; k < 9; k++) begin
      check_eq("held_ready", bus.cmd_ready, (k % 3) == 0);
      if (bus.cmd_ready) acc++;
      if ((k % 3) == 0) r5 = ref_regs[1] + 8'h01;
      @(negedge clk);
      #1;
      check_eq("held_res_valid", bus.res_valid, (k % 3) == 1);
      if (bus.res_valid) begin
        pulses++;
        check_eq("held_res_data", bus.res_data, r5);
      end
      if ((k % 3) == 2) ref_regs[1] = r5;
    end
    bus.cmd_valid = 1'b0;
    check_eq("held_accepts", acc, 3);
    check_eq("held_pulses", pulses, 3);
    bus.dbg_addr = 2'd1;
    #1;
    check_eq("held_r1", bus.dbg_data, ref_regs[1]);

    // Reset pulsed during EXEC of ADD R1 = R1 + R1.
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = 2'b10;
    bus.cmd_rd     = 2'd1;
    bus.cmd_rs1    = 2'd1;
    bus.cmd_rs2    = 2'd1;
    bus.cmd_imm_en = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    reset         = 1'b1;
    #1;
    check_eq("midrst_res_valid", bus.res_valid, 0);
    check_eq("midrst_alu_a", bus.alu_a, 0);
    @(negedge clk);
    check_eq("midrst_res_valid2", bus.res_valid, 0);
    reset = 1'b0;
    clear_model();
    check_reset_state();
    @(negedge clk);
    check_eq("postrst_res_valid", bus.res_valid, 0);
    check_eq("postrst_ready", bus.cmd_ready, 1);
    bus.dbg_addr = 2'd1;
    #1;
    check_eq("postrst_r1", bus.dbg_data, 8'h00);

    // Randomized commands, including don't-care rs2 and junk during EXEC.
    for (int n = 0; n < 150; n++) begin
      ie = 1'($urandom);
      run_cmd(2'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), ie, 8'($urandom), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
